// File: rtl/ex_mem.sv
// ---------------------------------------------------------------------------
// ex_mem -- EX/MEM pipeline register.
//
// Carries the execute-stage register-write bundle and HI/LO bundle into the
// memory stage with one cycle of latency.
//
// Per-edge decode, highest priority first:
//   reset -> flush -> stall decode -> capture
//
//   stall_ex stall_mem | mem_* bundle | acc state
//   -------------------+--------------+------------------
//      0        0      | capture ex_* | cleared
//      1        0      | bubble       | load acc_*_i
//      1        1      | hold         | hold
//      0        1      | hold         | hold   (illegal combination)
//
// The accumulate state carries the partial multiply-accumulate product and
// step count across a multi-cycle execute stall, and hands it back to
// execute.
//
// Compile-time option:
//   EX_MEM_MADD_EN
//     Defined   : the accumulate registers exist.
//     Undefined : acc_temp_i and acc_cnt_i are ignored, and acc_temp_o and
//                 acc_cnt_o are tied to zero.
//
// Ports:
//   clk, reset            : clock; synchronous active-high reset
//   flush                 : pipeline flush; inserts a bubble and clears acc
//   stall_ex, stall_mem   : stage stall controls
//   ex_addr/en/data       : execute register-write bundle
//   ex_hilo_en/hi/lo      : execute HI/LO bundle
//   acc_temp_i, acc_cnt_i : accumulate state from execute
//   mem_addr/en/data      : registered register-write bundle
//   mem_hilo_en/hi/lo     : registered HI/LO bundle
//   acc_temp_o, acc_cnt_o : held accumulate state returned to execute
//   pip_en/hi/lo          : combinational copies of the mem HI/LO bundle,
//                           used for HI/LO forwarding into execute
// ---------------------------------------------------------------------------
module ex_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall_ex,
  input  logic        stall_mem,
  input  logic [4:0]  ex_addr,
  input  logic        ex_en,
  input  logic [31:0] ex_data,
  input  logic        ex_hilo_en,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [63:0] acc_temp_i,
  input  logic [1:0]  acc_cnt_i,
  output logic [4:0]  mem_addr,
  output logic        mem_en,
  output logic [31:0] mem_data,
  output logic        mem_hilo_en,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic [63:0] acc_temp_o,
  output logic [1:0]  acc_cnt_o,
  output logic        pip_en,
  output logic [31:0] pip_hi,
  output logic [31:0] pip_lo
);

  typedef struct packed {
    logic [4:0]  addr;
    logic        en;
    logic [31:0] data;
    logic        hilo_en;
    logic [31:0] hi;
    logic [31:0] lo;
  } wb_t;

  wb_t ex_b, mem_q;

  logic capture, bubble;

  assign ex_b = '{addr: ex_addr, en: ex_en, data: ex_data,
                  hilo_en: ex_hilo_en, hi: ex_hi, lo: ex_lo};

  // Any combination with stall_mem set (including the illegal 0/1 case)
  // falls through to hold.
  assign capture = ~stall_ex & ~stall_mem;
  assign bubble  =  stall_ex & ~stall_mem;

  // A bubble is all zero, so it never re-asserts either write enable while
  // the same instruction is still in execute.
  always_ff @(posedge clk) begin
    if (reset || flush) mem_q <= '0;
    else if (capture)   mem_q <= ex_b;
    else if (bubble)    mem_q <= '0;
  end

  assign mem_addr    = mem_q.addr;
  assign mem_en      = mem_q.en;
  assign mem_data    = mem_q.data;
  assign mem_hilo_en = mem_q.hilo_en;
  assign mem_hi      = mem_q.hi;
  assign mem_lo      = mem_q.lo;

  // Forwarding taps: wires only, with no extra state.
  assign pip_en = mem_q.hilo_en;
  assign pip_hi = mem_q.hi;
  assign pip_lo = mem_q.lo;

`ifdef EX_MEM_MADD_EN
  logic [63:0] acc_temp_q;
  logic [1:0]  acc_cnt_q;

  // The step count is passed through unaltered from execute. Execute owns
  // the 0->1->2 sequencing; this block never increments or wraps it.
  always_ff @(posedge clk) begin
    if (reset || flush || capture) begin
      acc_temp_q <= '0;
      acc_cnt_q  <= '0;
    end else if (bubble) begin
      acc_temp_q <= acc_temp_i;
      acc_cnt_q  <= acc_cnt_i;
    end
  end

  assign acc_temp_o = acc_temp_q;
  assign acc_cnt_o  = acc_cnt_q;
`else
  logic unused_acc;
  assign unused_acc = ^{acc_temp_i, acc_cnt_i};
  assign acc_temp_o = '0;
  assign acc_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// ---------------------------------------------------------------------------
// tb_ex_mem -- scoreboard bench for ex_mem.
//
// The stimulus process drives the inputs and applies the pipeline rules to a
// behavioural copy of the stage. After each clock edge it pushes the
// expected state onto a queue. A separate monitor runs on the falling edge,
// pops one entry per cycle and compares it with every DUT output.
//
// Directed cases cover reset, capture, bubble, hold, the illegal stall
// combination, flush during a stall, the accumulate step count, HI/LO
// forwarding and reset in the middle of a stall. Randomized cycles follow.
// ---------------------------------------------------------------------------
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        reset, flush, stall_ex, stall_mem;
  logic [4:0]  ex_addr;
  logic        ex_en;
  logic [31:0] ex_data;
  logic        ex_hilo_en;
  logic [31:0] ex_hi, ex_lo;
  logic [63:0] acc_temp_i;
  logic [1:0]  acc_cnt_i;
  logic [4:0]  mem_addr;
  logic        mem_en;
  logic [31:0] mem_data;
  logic        mem_hilo_en;
  logic [31:0] mem_hi, mem_lo;
  logic [63:0] acc_temp_o;
  logic [1:0]  acc_cnt_o;
  logic        pip_en;
  logic [31:0] pip_hi, pip_lo;

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .reset(reset), .flush(flush),
    .stall_ex(stall_ex), .stall_mem(stall_mem),
    .ex_addr(ex_addr), .ex_en(ex_en), .ex_data(ex_data),
    .ex_hilo_en(ex_hilo_en), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .acc_temp_i(acc_temp_i), .acc_cnt_i(acc_cnt_i),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .mem_hilo_en(mem_hilo_en), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .acc_temp_o(acc_temp_o), .acc_cnt_o(acc_cnt_o),
    .pip_en(pip_en), .pip_hi(pip_hi), .pip_lo(pip_lo)
  );

`ifdef EX_MEM_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic        en;
    logic [31:0] data;
    logic        hilo_en;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] acc_temp;
    logic [1:0]  acc_cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference behaviour of one clock edge, written as the rule table.
  function automatic exp_t model(input exp_t s);
    exp_t n;
    exp_t z;
    z = '{addr: 0, en: 0, data: 0, hilo_en: 0, hi: 0, lo: 0,
          acc_temp: 0, acc_cnt: 0};
    n = s;
    if (reset || flush) begin
      n = z;
    end else if (!stall_ex && !stall_mem) begin
      n = '{addr: ex_addr, en: ex_en, data: ex_data, hilo_en: ex_hilo_en,
            hi: ex_hi, lo: ex_lo, acc_temp: 0, acc_cnt: 0};
    end else if (stall_ex && !stall_mem) begin
      n = z;
      if (MADD) begin
        n.acc_temp = acc_temp_i;
        n.acc_cnt  = acc_cnt_i;
      end
    end
    return n;
  endfunction

  // Apply the current inputs for one edge, then queue the expected state.
  task automatic step();
    m = model(m);
    @(posedge clk);
    #1;
    q.push_back(m);
  endtask

  task automatic idle();
    reset = 0; flush = 0; stall_ex = 0; stall_mem = 0;
    ex_addr = 0; ex_en = 0; ex_data = 0; ex_hilo_en = 0;
    ex_hi = 0; ex_lo = 0; acc_temp_i = 0; acc_cnt_i = 0;
  endtask

  // Monitor: one scoreboard entry per cycle, compared away from the edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("mem_addr",    64'(mem_addr),    64'(e.addr));
      chk("mem_en",      64'(mem_en),      64'(e.en));
      chk("mem_data",    64'(mem_data),    64'(e.data));
      chk("mem_hilo_en", 64'(mem_hilo_en), 64'(e.hilo_en));
      chk("mem_hi",      64'(mem_hi),      64'(e.hi));
      chk("mem_lo",      64'(mem_lo),      64'(e.lo));
      chk("acc_temp_o",  acc_temp_o,       e.acc_temp);
      chk("acc_cnt_o",   64'(acc_cnt_o),   64'(e.acc_cnt));
      chk("pip_en",      64'(pip_en),      64'(e.hilo_en));
      chk("pip_hi",      64'(pip_hi),      64'(e.hi));
      chk("pip_lo",      64'(pip_lo),      64'(e.lo));
    end
  end

  initial begin
    idle();
    m = '{addr: 0, en: 0, data: 0, hilo_en: 0, hi: 0, lo: 0,
          acc_temp: 0, acc_cnt: 0};

    // Reset while a valid write is presented.
    reset = 1; ex_en = 1; ex_data = 32'hDEADBEEF;
    step(); #2;
    chk("rst_data", 64'(mem_data), 64'h0);
    chk("rst_en",   64'(mem_en),   64'h0);
    reset = 0;
    step(); #2;
    chk("post_rst_data", 64'(mem_data), 64'hDEADBEEF);
    chk("post_rst_en",   64'(mem_en),   64'h1);

    // Normal capture.
    ex_addr = 5'd9; ex_data = 32'h12345678; ex_en = 1;
    step(); #2;
    chk("cap_addr", 64'(mem_addr), 64'd9);
    chk("cap_data", 64'(mem_data), 64'h12345678);

    // Execute stall: a bubble goes into mem and the accumulator is loaded.
    stall_ex = 1; acc_temp_i = 64'h0000_0001_0000_0002; acc_cnt_i = 1;
    step(); #2;
    chk("bub_en",   64'(mem_en),   64'h0);
    chk("bub_data", 64'(mem_data), 64'h0);
    chk("acc_temp", acc_temp_o, MADD ? 64'h0000_0001_0000_0002 : 64'h0);
    chk("acc_cnt1", 64'(acc_cnt_o), MADD ? 64'd1 : 64'd0);
    acc_cnt_i = 2;
    step(); #2;
    chk("acc_cnt2", 64'(acc_cnt_o), MADD ? 64'd2 : 64'd0);

    // Capture, then a full stall for three cycles: the stage must hold.
    idle(); ex_data = 32'hA5A5A5A5; ex_en = 1; ex_addr = 5'd3;
    step();
    stall_ex = 1; stall_mem = 1;
    for (int i = 0; i < 3; i++) begin
      ex_data = $urandom; ex_en = 0;
      step(); #2;
      chk("hold_data", 64'(mem_data), 64'hA5A5A5A5);
      chk("hold_en",   64'(mem_en),   64'h1);
    end

    // Illegal stall combination also holds.
    stall_ex = 0; stall_mem = 1; ex_data = 32'h0BADF00D; ex_en = 1;
    step(); #2;
    chk("illegal_hold", 64'(mem_data), 64'hA5A5A5A5);

    // Flush during a full stall clears everything, including acc_cnt=2.
    idle(); stall_ex = 1; acc_cnt_i = 2; acc_temp_i = 64'h55;
    step();
    flush = 1; stall_ex = 1; stall_mem = 1;
    step(); #2;
    chk("flush_en",  64'(mem_en),    64'h0);
    chk("flush_cnt", 64'(acc_cnt_o), 64'h0);

    // HI/LO capture, visible on the forwarding taps at the same time.
    idle(); ex_hilo_en = 1; ex_hi = 32'h11; ex_lo = 32'h22;
    step(); #2;
    chk("pip_en_d", 64'(pip_en), 64'h1);
    chk("pip_hi_d", 64'(pip_hi), 64'h11);
    chk("pip_lo_d", 64'(pip_lo), 64'h22);

    // Reset in the middle of an accumulate stall discards the held state.
    idle(); stall_ex = 1; acc_temp_i = 64'hFFFF; acc_cnt_i = 1;
    step();
    reset = 1; stall_mem = 1;
    step();
    idle(); ex_addr = 5'd17; ex_en = 1; ex_data = 32'hCAFEF00D;
    step(); #2;
    chk("rst_mid_data", 64'(mem_data), 64'hCAFEF00D);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 99) < 2);
      flush      = ($urandom_range(0, 99) < 5);
      stall_ex   = ($urandom_range(0, 99) < 30);
      stall_mem  = stall_ex ? ($urandom_range(0, 1) == 1)
                            : ($urandom_range(0, 99) < 5);
      ex_addr    = 5'($urandom);
      ex_en      = 1'($urandom);
      ex_data    = $urandom;
      ex_hilo_en = 1'($urandom);
      ex_hi      = $urandom;
      ex_lo      = $urandom;
      acc_temp_i = {$urandom, $urandom};
      acc_cnt_i  = 2'($urandom_range(0, 2));
      step();
    end

    idle();
    #10;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
